// File: rtl/ctrl_decode.sv
// Registered decoder for the addu/subu/jr/ori/lw/sw/beq/lui/j/jal subset.
// Produces one-hot instruction flags plus datapath controls aligned with ID/EX.
module ctrl_decode (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flush,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    output logic       R,
    output logic       addu,
    output logic       subu,
    output logic       jr,
    output logic       ori,
    output logic       lw,
    output logic       sw,
    output logic       beq,
    output logic       lui,
    output logic       j,
    output logic       jal,
    output logic       undef,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUSrc,
    output logic       RegWrite,
    output logic [1:0] WRSel,
    output logic [1:0] WDSel,
    output logic       MemWrite,
    output logic [1:0] NPCOp
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef struct packed {
        logic       r;
        logic       addu;
        logic       subu;
        logic       jr;
        logic       ori;
        logic       lw;
        logic       sw;
        logic       beq;
        logic       lui;
        logic       j;
        logic       jal;
        logic       undef;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic       reg_write;
        logic [1:0] wr_sel;
        logic [1:0] wd_sel;
        logic       mem_write;
        logic [1:0] npc_op;
    } ctrl_t;

    ctrl_t dec;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    always_comb begin
        dec   = '0;
        dec.r = (Op == OP_RTYPE);

        case (Op)
            OP_RTYPE: begin
                case (Func)
                    FN_ADDU: dec.addu  = 1'b1;
                    FN_SUBU: dec.subu  = 1'b1;
                    FN_JR:   dec.jr    = 1'b1;
                    default: dec.undef = 1'b1;
                endcase
            end
            OP_ORI:  dec.ori   = 1'b1;
            OP_LW:   dec.lw    = 1'b1;
            OP_SW:   dec.sw    = 1'b1;
            OP_BEQ:  dec.beq   = 1'b1;
            OP_LUI:  dec.lui   = 1'b1;
            OP_J:    dec.j     = 1'b1;
            OP_JAL:  dec.jal   = 1'b1;
            default: dec.undef = 1'b1;
        endcase

        // Derived controls come only from the flags, so undef leaves them all 0.
        if (dec.ori)
            dec.alu_op = 4'd1;
        else if (dec.addu || dec.lw || dec.sw)
            dec.alu_op = 4'd2;
        else if (dec.subu)
            dec.alu_op = 4'd3;
        else if (dec.lui)
            dec.alu_op = 4'd4;

        if (dec.ori || dec.lui)
            dec.alu_src = 2'd1;
        else if (dec.lw || dec.sw)
            dec.alu_src = 2'd2;

        dec.reg_write = dec.addu | dec.subu | dec.ori | dec.lw | dec.lui | dec.jal;

        if (dec.addu || dec.subu)
            dec.wr_sel = 2'd1;
        else if (dec.jal)
            dec.wr_sel = 2'd2;

        if (dec.lw)
            dec.wd_sel = 2'd1;
        else if (dec.jal)
            dec.wd_sel = 2'd2;

        dec.mem_write = dec.sw;

        if (dec.beq)
            dec.npc_op = 2'd1;
        else if (dec.j || dec.jal)
            dec.npc_op = 2'd2;
        else if (dec.jr)
            dec.npc_op = 2'd3;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (flush)
            ctrl_d = '0;
        else if (en)
            ctrl_d = dec;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ctrl_q <= '0;
        else
            ctrl_q <= ctrl_d;
    end

    assign R        = ctrl_q.r;
    assign addu     = ctrl_q.addu;
    assign subu     = ctrl_q.subu;
    assign jr       = ctrl_q.jr;
    assign ori      = ctrl_q.ori;
    assign lw       = ctrl_q.lw;
    assign sw       = ctrl_q.sw;
    assign beq      = ctrl_q.beq;
    assign lui      = ctrl_q.lui;
    assign j        = ctrl_q.j;
    assign jal      = ctrl_q.jal;
    assign undef    = ctrl_q.undef;
    assign ALUOp    = ctrl_q.alu_op;
    assign ALUSrc   = ctrl_q.alu_src;
    assign RegWrite = ctrl_q.reg_write;
    assign WRSel    = ctrl_q.wr_sel;
    assign WDSel    = ctrl_q.wd_sel;
    assign MemWrite = ctrl_q.mem_write;
    assign NPCOp    = ctrl_q.npc_op;

endmodule

// File: tb/tb_ctrl_decode.sv
// Testbench for ctrl_decode: directed vector table, hand-written stall/flush/reset
// sequences, and randomized traffic against a table-based reference model.
module tb_ctrl_decode;

    logic       clk = 1'b0;
    logic       reset, en, flush;
    logic [5:0] Op, Func;
    logic       R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal, undef;
    logic [3:0] ALUOp;
    logic [1:0] ALUSrc, WRSel, WDSel, NPCOp;
    logic       RegWrite, MemWrite;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_decode dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .Op(Op), .Func(Func),
        .R(R), .addu(addu), .subu(subu), .jr(jr), .ori(ori), .lw(lw), .sw(sw),
        .beq(beq), .lui(lui), .j(j), .jal(jal), .undef(undef),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .WRSel(WRSel),
        .WDSel(WDSel), .MemWrite(MemWrite), .NPCOp(NPCOp)
    );

    // {R, addu..jal, undef, ALUOp, ALUSrc, RegWrite, WRSel, WDSel, MemWrite, NPCOp}
    wire [25:0] dut_vec = {R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal, undef,
                           ALUOp, ALUSrc, RegWrite, WRSel, WDSel, MemWrite, NPCOp};
    wire [10:0] dut_flags = {addu, subu, jr, ori, lw, sw, beq, lui, j, jal, undef};

    function automatic logic [25:0] pk(input logic r, input logic [10:0] fl,
                                       input logic [3:0] aop, input logic [1:0] asrc,
                                       input logic rw, input logic [1:0] wrs,
                                       input logic [1:0] wds, input logic mw,
                                       input logic [1:0] npc);
        return {r, fl, aop, asrc, rw, wrs, wds, mw, npc};
    endfunction

    // Reference model: match against the list of supported encodings, then look
    // the controls up per instruction index.
    function automatic logic [25:0] model(input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] enc_op  [10] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h02, 6'h03};
        logic [5:0] enc_fn  [10] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        int         t_alu   [10] = '{2, 3, 0, 1, 2, 2, 0, 4, 0, 0};
        int         t_src   [10] = '{0, 0, 0, 1, 2, 2, 0, 1, 0, 0};
        int         t_rw    [10] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 1};
        int         t_wrs   [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 2};
        int         t_wds   [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        int         t_mw    [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int         t_npc   [10] = '{0, 0, 3, 0, 0, 0, 1, 0, 2, 2};
        int k = -1;
        logic r = (op == 6'd0);
        for (int i = 0; i < 10; i++)
            if (op == enc_op[i] && (op != 6'd0 || fn == enc_fn[i])) k = i;
        if (k < 0) return pk(r, 11'b1, 4'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        return pk(r, 11'b1 << (10 - k), 4'(t_alu[k]), 2'(t_src[k]), 1'(t_rw[k]),
                  2'(t_wrs[k]), 2'(t_wds[k]), 1'(t_mw[k]), 2'(t_npc[k]));
    endfunction

    task automatic check(input string name, input logic [25:0] exp);
        n_checks++;
        if (dut_vec !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, dut_vec, exp);
        end
    endtask

    task automatic check_onehot(input string name);
        n_checks++;
        if ($countones(dut_flags) != 1) begin
            n_fail++;
            $display("FAIL %s onehot: flags %b required exactly one set", name, dut_flags);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic rst_i, input logic en_i, input logic fl_i,
                        input logic [5:0] op_i, input logic [5:0] fn_i);
        reset = rst_i; en = en_i; flush = fl_i; Op = op_i; Func = fn_i;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [25:0] exp;
    } vec_t;

    vec_t vt[$];
    logic [25:0] zero = '0;

    initial begin
        logic [25:0] exp_q;
        logic [5:0]  rop, rfn;
        logic        rr, re, rf;
        logic [5:0]  ops [11] = '{6'h00, 6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h02, 6'h03, 6'h3f, 6'h01};
        logic [5:0]  fns [4]  = '{6'h21, 6'h23, 6'h08, 6'h00};

        vt.push_back('{"addu",  6'h00, 6'h21, pk(1, 11'b10000000000, 2, 0, 1, 1, 0, 0, 0)});
        vt.push_back('{"subu",  6'h00, 6'h23, pk(1, 11'b01000000000, 3, 0, 1, 1, 0, 0, 0)});
        vt.push_back('{"jr",    6'h00, 6'h08, pk(1, 11'b00100000000, 0, 0, 0, 0, 0, 0, 3)});
        vt.push_back('{"ori",   6'h0d, 6'h21, pk(0, 11'b00010000000, 1, 1, 1, 0, 0, 0, 0)});
        vt.push_back('{"lw",    6'h23, 6'h00, pk(0, 11'b00001000000, 2, 2, 1, 0, 1, 0, 0)});
        vt.push_back('{"sw",    6'h2b, 6'h08, pk(0, 11'b00000100000, 2, 2, 0, 0, 0, 1, 0)});
        vt.push_back('{"beq",   6'h04, 6'h3f, pk(0, 11'b00000010000, 0, 0, 0, 0, 0, 0, 1)});
        vt.push_back('{"lui",   6'h0f, 6'h23, pk(0, 11'b00000001000, 4, 1, 1, 0, 0, 0, 0)});
        vt.push_back('{"j",     6'h02, 6'h00, pk(0, 11'b00000000100, 0, 0, 0, 0, 0, 0, 2)});
        vt.push_back('{"jal",   6'h03, 6'h21, pk(0, 11'b00000000010, 0, 0, 1, 2, 2, 0, 2)});
        vt.push_back('{"r_fn0", 6'h00, 6'h00, pk(1, 11'b00000000001, 0, 0, 0, 0, 0, 0, 0)});
        vt.push_back('{"r_fn3f",6'h00, 6'h3f, pk(1, 11'b00000000001, 0, 0, 0, 0, 0, 0, 0)});
        vt.push_back('{"op3f",  6'h3f, 6'h21, pk(0, 11'b00000000001, 0, 0, 0, 0, 0, 0, 0)});

        // Reset for 2 cycles with jal presented, then release.
        step(1, 1, 0, 6'h03, 6'h00);
        check("reset_c1", zero);
        step(1, 1, 0, 6'h03, 6'h00);
        check("reset_c2", zero);
        step(0, 1, 0, 6'h03, 6'h00);
        check("post_reset_jal", pk(0, 11'b00000000010, 0, 0, 1, 2, 2, 0, 2));

        foreach (vt[i]) begin
            step(0, 1, 0, vt[i].op, vt[i].fn);
            check(vt[i].name, vt[i].exp);
            check_onehot(vt[i].name);
        end

        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 6'h04, 6'($urandom));
            check("beq_randfn", pk(0, 11'b00000010000, 0, 0, 0, 0, 0, 0, 1));
        end

        // Stall: lw captured, then en=0 with lui on the inputs.
        step(0, 1, 0, 6'h23, 6'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 6'h0f, 6'h00);
            check("hold_lw", pk(0, 11'b00001000000, 2, 2, 1, 0, 1, 0, 0));
        end
        step(0, 1, 0, 6'h0f, 6'h00);
        check("lui_after_hold", pk(0, 11'b00000001000, 4, 1, 1, 0, 0, 0, 0));

        // flush beats the stall.
        step(0, 0, 1, 6'h0d, 6'h00);
        check("flush_en0", zero);
        step(0, 1, 0, 6'h0d, 6'h00);
        step(1, 1, 1, 6'h0d, 6'h00);
        check("reset_and_flush", zero);
        step(0, 1, 0, 6'h00, 6'h21);
        step(1, 0, 0, 6'h00, 6'h21);
        check("reset_en0", zero);
        step(0, 0, 0, 6'h00, 6'h21);
        check("hold_bubble", zero);

        // Randomized traffic against the model.
        exp_q = zero;
        for (int i = 0; i < 400; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
            rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 3)];
            rr  = ($urandom_range(0, 29) == 0);
            rf  = ($urandom_range(0, 14) == 0);
            re  = ($urandom_range(0, 3) != 0);
            if (rr || rf)
                exp_q = zero;
            else if (re)
                exp_q = model(rop, rfn);
            step(rr, re, rf, rop, rfn);
            check("random", exp_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
